// File: rtl/prog_counter.sv
// Programmable counter: width/prescale parametrised, up/down, synchronous load,
// programmable terminal value, one-shot halt, terminal-count pulse and compare match.
module prog_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      max_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  one_shot,
    input  logic [WIDTH-1:0]      cmp_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  cmp_match,
    output logic                  running
);

    logic [PRESCALE_W-1:0] pcnt;
    logic                  halted;
    logic                  active;
    logic                  tick;
    logic                  at_terminal;
    logic                  terminal;
    logic [WIDTH-1:0]      step_val;
    logic [WIDTH-1:0]      wrap_val;

    assign active = en && !halted;
    assign tick   = active && (pcnt == prescale);

    // Up-counting treats anything at or above max_val as terminal, so a load
    // beyond the range wraps on the next tick instead of running to 2^WIDTH.
    always_comb begin
        at_terminal = 1'b0;
        step_val    = count;
        wrap_val    = '0;
        if (dir) begin
            at_terminal = (count == '0);
            step_val    = count - 1'b1;
            wrap_val    = max_val;
        end else begin
            at_terminal = (count >= max_val);
            step_val    = count + 1'b1;
            wrap_val    = '0;
        end
    end

    assign terminal = tick && at_terminal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            pcnt   <= '0;
            tc     <= 1'b0;
            halted <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            pcnt   <= '0;
            tc     <= 1'b0;
            halted <= 1'b0;
        end else begin
            tc <= terminal;
            if (active) begin
                if (tick) begin
                    pcnt <= '0;
                    if (!at_terminal) begin
                        count <= step_val;
                    end else if (one_shot) begin
                        halted <= 1'b1;
                    end else begin
                        count <= wrap_val;
                    end
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end
        end
    end

    assign cmp_match = (count == cmp_val);
    assign running   = !halted;

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised programmable counter: the next-generation replacement for the free-running 8-bit counter used on the demo top level. Adds configurable width, enable, up/down direction, synchronous load, programmable terminal count (modulo), a clock prescaler, one-shot mode, terminal-count pulse and compare match. Instantiated under a top-level wrapper that maps its ports onto dedicated and bidirectional pins.

## Interface

Parameters:
- WIDTH, 8: counter width in bits; legal range ≥ 2.
- PRESCALE_W, 8: prescaler width in bits; legal range ≥ 1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  count enable; prescaler and counter frozen while low.
- dir  input  1  0 = count up, 1 = count down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value written to count on load.
- max_val  input  WIDTH  terminal value; count range is 0..max_val.
- prescale  input  PRESCALE_W  counter advances once every prescale+1 enabled cycles.
- one_shot  input  1  1 = halt at terminal instead of wrapping.
- cmp_val  input  WIDTH  compare value.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- cmp_match  output  1  combinational count == cmp_val.
- running  output  1  0 while halted in one-shot mode (registered state).

## Operation

- State: count[WIDTH], pcnt[PRESCALE_W], tc, halted.
- Reset (async, rst=1): count=0, pcnt=0, tc=0, halted=0; so running=1 and cmp_match = (cmp_val==0).
- Priority per edge: rst > load > tick > hold.
- Load: count<=load_val, pcnt<=0, halted<=0, tc<=0. load ignores en.
- Prescaler: while en=1 and not halted, tick = (pcnt==prescale); on tick pcnt<=0, else pcnt<=pcnt+1. en=0 holds pcnt. prescale=0 → tick every enabled cycle. prescale changed mid-count with pcnt>prescale: pcnt counts on, wraps at 2^PRESCALE_W; no tick until it equals prescale.
- Tick, up (dir=0): count≥max_val → terminal event; else count<=count+1.
- Tick, down (dir=1): count==0 → terminal event; else count<=count-1 (including count>max_val after a load).
- Terminal event, one_shot=0: count<=0 (up) or max_val (down); tc<=1.
- Terminal event, one_shot=1: count holds; halted<=1; tc<=1. While halted, no ticks, pcnt holds, tc=0. Only load or rst clears halted.
- tc<=0 on every edge without a terminal event.
- max_val=0: up and down both give terminal event every tick, count stays 0.
- Arithmetic is modulo 2^WIDTH; no overflow path reachable except via count≥max_val wrap.
- dir, max_val, one_shot sampled each tick; changes take effect on the next tick.

## Timing

- count, tc, running: registered, change only at clk edge (or async on rst).
- cmp_match: combinational from count and cmp_val; no added latency.
- From en rising (pcnt=0): first count change at edge prescale+1.
- tc is high for exactly the one cycle following the edge of the terminal event, concurrent with the wrapped/held count.
- Load and tick on the same edge: load wins, tick lost, pcnt cleared.
- rst asserted mid-count: outputs reach reset values immediately; first tick after release needs prescale+1 enabled cycles.

## Test plan

- Reset then en=1, dir=0, prescale=0, max_val=255, one_shot=0 for 260 cycles → count 0,1,…,255,0,1,2,3; tc high for the single cycle count returns to 0.
- prescale=3, max_val=5, dir=0 → count steps every 4 cycles 0..5 then 0; tc one cycle per 24 cycles; en dropped for 10 cycles mid-period → count and phase frozen.
- dir=1, max_val=9, load load_val=2 → count 2,1,0,9,8; tc with the 9; then load load_val=200 → count 199,198.
- one_shot=1, dir=0, max_val=3 → count 0,1,2,3 then holds at 3, tc one cycle, running=0 thereafter; load load_val=0 → running=1, counting resumes.
- cmp_val=7, count up → cmp_match high exactly while count==7; load and tick on same edge with load_val=50 → count=50, not 51.
- rst pulsed asynchronously (between edges) at count=100 → count=0, tc=0, running=1 before next edge; max_val=0 → count stays 0, tc high every tick.
